// File: rtl/ladd_seq_ctrl.sv
// Job sequencer for the nibble-pipelined accumulator.
// Clears the accumulator, streams LEN operands into it over a valid/ready
// handshake, waits out the pipeline latency, then captures the sum and pulses done.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; all outputs low
// CLEAR | one-cycle accumulator clear; job length already latched
// RUN   | in_ready high; each handshake forwards one operand
// DRAIN | wait for the pipeline to settle; capture sum on last cycle
// DONE  | one-cycle done pulse, result valid
// FLUSH | one-cycle accumulator clear after an abort; no done
module ladd_seq_ctrl #(
    parameter int W     = 8,
    parameter int CNTW  = 8,
    parameter int DRAIN = 3
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start_i,
    input  logic [CNTW-1:0] len_i,
    input  logic            abort_i,
    output logic            busy_o,
    input  logic            in_valid_i,
    input  logic [W-1:0]    in_data_i,
    output logic            in_ready_o,
    output logic            acc_clr_o,
    output logic            acc_ld_o,
    output logic [W-1:0]    acc_x_o,
    input  logic [W-1:0]    acc_a_i,
    output logic [W-1:0]    result_o,
    output logic            done_o
);

    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    state_t          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [DW-1:0]   drn_q;
    logic [W-1:0]    result_q;
    logic            busy_q;
    logic            in_ready_q;
    logic            acc_clr_q;
    logic            done_q;
    logic            xfer;

    // A transfer needs the registered ready; abort suppresses it so a
    // cancelled job never pushes one more operand into the accumulator.
    assign xfer = in_ready_q & in_valid_i & ~abort_i;

    assign busy_o     = busy_q;
    assign in_ready_o = in_ready_q;
    assign acc_clr_o  = acc_clr_q;
    assign acc_ld_o   = xfer;
    assign acc_x_o    = xfer ? in_data_i : '0;
    assign result_o   = result_q;
    assign done_o     = done_q;

    // Sequencer: state, counters and registered outputs, all set for the next state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            drn_q      <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        cnt_q     <= len_i;
                        busy_q    <= 1'b1;
                        acc_clr_q <= 1'b1;
                        state_q   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (abort_i) begin
                        state_q <= ST_FLUSH;
                    end else if (cnt_q == '0) begin
                        acc_clr_q <= 1'b0;
                        drn_q     <= DW'(DRAIN - 1);
                        state_q   <= ST_DRAIN;
                    end else begin
                        acc_clr_q  <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        in_ready_q <= 1'b0;
                        acc_clr_q  <= 1'b1;
                        state_q    <= ST_FLUSH;
                    end else if (xfer) begin
                        cnt_q <= cnt_q - CNTW'(1);
                        if (cnt_q == CNTW'(1)) begin
                            in_ready_q <= 1'b0;
                            drn_q      <= DW'(DRAIN - 1);
                            state_q    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort_i) begin
                        acc_clr_q <= 1'b1;
                        state_q   <= ST_FLUSH;
                    end else if (drn_q == '0) begin
                        result_q <= acc_a_i;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        drn_q <= drn_q - DW'(1);
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    if (abort_i) begin
                        acc_clr_q <= 1'b1;
                        state_q   <= ST_FLUSH;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    acc_clr_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                    acc_clr_q  <= 1'b0;
                    done_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ladd_seq_ctrl.sv
// Bench for ladd_seq_ctrl: table of complete jobs plus hand-written
// abort, busy-start, idle-abort and async-reset sequences.
// A small pipelined accumulator stands in for the datapath (sum reaches
// acc_a three cycles after the operand is presented).
module tb_ladd_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       abort = 1'b0;
    logic       busy;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       acc_clr;
    logic       acc_ld;
    logic [7:0] acc_x;
    logic [7:0] acc_a;
    logic [7:0] result;
    logic       done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ladd_seq_ctrl #(.W(8), .CNTW(8), .DRAIN(3)) dut (
        .clk(clk), .rst_b(rst_b),
        .start_i(start), .len_i(len), .abort_i(abort), .busy_o(busy),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .acc_clr_o(acc_clr), .acc_ld_o(acc_ld), .acc_x_o(acc_x),
        .acc_a_i(acc_a), .result_o(result), .done_o(done)
    );

    // accumulator stand-in: one add stage plus two delay stages
    logic [7:0] m_acc, m_d1, m_d2;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_acc <= '0; m_d1 <= '0; m_d2 <= '0;
        end else if (acc_clr) begin
            m_acc <= '0; m_d1 <= '0; m_d2 <= '0;
        end else begin
            m_acc <= m_acc + acc_x;
            m_d1  <= m_acc;
            m_d2  <= m_d1;
        end
    end
    assign acc_a = m_d2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    typedef struct {
        logic [7:0]      len;
        logic [4:0][7:0] d;       // d[0] is the first operand
        logic [7:0]      vmask;   // in_valid for the k-th in_ready cycle = vmask[k%8]
        logic [7:0]      exp_res;
        int              exp_rdy; // cycles with in_ready high
        int              exp_edge;// edge (start-sampling edge = 1) after which done is high
    } vec_t;

    vec_t vt[6];

    task automatic run_job(input vec_t v, input int id);
        int  edges = 0, rdy = 0, clr = 0, dn = 0, done_edge = -1, k = 0, idx = 0, bad = 0;
        bit  fin = 0;
        string tag;
        tag = $sformatf("job%0d", id);
        @(negedge clk);
        start = 1'b1; len = v.len;
        @(posedge clk); edges = 1;
        @(negedge clk);
        start = 1'b0; len = ~v.len;
        for (int c = 0; c < 60 && !fin; c++) begin
            if (acc_clr) clr++;
            if (done) begin dn++; if (done_edge < 0) done_edge = edges; end
            if (in_ready) begin
                rdy++;
                in_valid = v.vmask[k % 8];
                in_data  = (idx < 5) ? v.d[idx] : 8'h77;
                k++;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'hA5;
            end
            #1;
            if (in_ready && in_valid) begin
                if (!acc_ld || acc_x !== in_data) bad++;
                idx++;
            end else if (acc_ld || acc_x !== 8'h00) begin
                bad++;
            end
            if (!busy && dn > 0) fin = 1;
            else begin
                @(posedge clk); edges++;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(v.exp_res));
        chk({tag, "_done_edge"}, 32'(done_edge), 32'(v.exp_edge));
        chk({tag, "_ready_cycles"}, 32'(rdy), 32'(v.exp_rdy));
        chk({tag, "_transfers"}, 32'(idx), 32'(v.len));
        chk({tag, "_done_pulses"}, 32'(dn), 32'd1);
        chk({tag, "_clr_cycles"}, 32'(clr), 32'd1);
        chk({tag, "_acc_ld_x"}, 32'(bad), 32'd0);
    endtask

    initial begin
        vt[0] = '{len: 8'd3, d: {8'h00, 8'h00, 8'h03, 8'h02, 8'h01}, vmask: 8'hFF,
                  exp_res: 8'h06, exp_rdy: 3, exp_edge: 8};
        vt[1] = '{len: 8'd2, d: {8'h00, 8'h00, 8'h00, 8'h01, 8'h0F}, vmask: 8'hFF,
                  exp_res: 8'h10, exp_rdy: 2, exp_edge: 7};
        vt[2] = '{len: 8'd2, d: {8'h00, 8'h00, 8'h00, 8'h02, 8'hFF}, vmask: 8'hFF,
                  exp_res: 8'h01, exp_rdy: 2, exp_edge: 7};
        vt[3] = '{len: 8'd4, d: {8'h00, 8'h08, 8'h07, 8'h06, 8'h05}, vmask: 8'h49,
                  exp_res: 8'h1A, exp_rdy: 9, exp_edge: 14};
        vt[4] = '{len: 8'd0, d: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, vmask: 8'hFF,
                  exp_res: 8'h00, exp_rdy: 0, exp_edge: 5};
        vt[5] = '{len: 8'd5, d: {8'h50, 8'h40, 8'h30, 8'h20, 8'h10}, vmask: 8'h55,
                  exp_res: 8'hF0, exp_rdy: 9, exp_edge: 14};

        #12;
        chk("reset_outputs", {busy, in_ready, acc_clr, acc_ld, acc_x, result, done}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        for (int i = 0; i < 6; i++) run_job(vt[i], i);

        // abort with start in IDLE: abort wins, nothing starts
        @(negedge clk);
        abort = 1'b1; start = 1'b1; len = 8'd2;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("idle_abort_start", {30'd0, busy, acc_clr}, 32'd0);

        // abort after two transfers of a len=5 job; start pulsed while busy
        @(negedge clk);
        start = 1'b1; len = 8'd5;
        @(posedge clk);
        @(negedge clk);                         // CLEAR
        start = 1'b0; in_valid = 1'b1; in_data = 8'h01;
        @(posedge clk);
        @(negedge clk);                         // RUN, transfer 1
        start = 1'b1;
        chk("abort_run_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);                         // RUN, transfer 2
        start = 1'b0; in_data = 8'h02;
        @(posedge clk);
        @(negedge clk);                         // RUN, abort with valid operand
        abort = 1'b1; in_data = 8'h04;
        #1;
        chk("abort_no_ld", {23'd0, acc_ld, acc_x}, 32'd0);
        @(posedge clk);
        @(negedge clk);                         // FLUSH
        abort = 1'b0; in_valid = 1'b0;
        chk("flush_outputs", {28'd0, acc_clr, busy, in_ready, done}, 32'b1100);
        @(posedge clk);
        @(negedge clk);
        chk("flush_back_idle", {30'd0, busy, acc_clr}, 32'd0);
        begin
            int seen = 0;
            for (int c = 0; c < 10; c++) begin
                if (done || busy) seen++;
                @(negedge clk);
            end
            chk("abort_no_done_no_restart", 32'(seen), 32'd0);
        end
        chk("abort_result_held", 32'(result), 32'hF0);

        // async reset mid-job
        @(negedge clk);
        start = 1'b1; len = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h09;
        @(posedge clk);
        @(negedge clk);                         // RUN
        #2 rst_b = 1'b0;
        #1;
        chk("async_reset_outputs", {busy, in_ready, acc_clr, acc_ld, acc_x, result, done}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_b = 1'b1;
        run_job(vt[1], 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
